// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter with a one-entry holding register.
// Frames are sent LSB-first: start bit, DATA_BITS data bits, an optional parity
// bit (present when UART_TX_PARITY_EN is defined) and STOP_BITS stop bits. Each
// bit lasts OVERSAMPLING clk_in cycles.
// Ports:
//   clk_in        oversampled baud clock (baud x OVERSAMPLING)
//   rst_in        asynchronous active-high reset
//   tx_data_in    word to send, sampled when tx_valid_in & tx_ready_out
//   tx_valid_in   tx_data_in holds a valid word
//   tx_ready_out  holding register empty
//   tx_serial_out serial line, idles high, registered
//   tx_busy_out   a frame is on the line
//   tx_done_out   high during the last cycle of the final stop bit
module uart_tx #(
    parameter int OVERSAMPLING = 8,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic                 tx_valid_in,
    output logic                 tx_ready_out,
    output logic                 tx_serial_out,
    output logic                 tx_busy_out,
    output logic                 tx_done_out
);
    localparam int BW = $clog2(OVERSAMPLING);
    localparam int IW = $clog2(DATA_BITS);
    localparam int SW = $clog2(2 * OVERSAMPLING);
    localparam logic [BW-1:0] BAUD_LAST = BW'(OVERSAMPLING - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS * OVERSAMPLING - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par, par_d;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_d;
    logic                 full, full_d;
    logic [DATA_BITS-1:0] hold, hold_d;
    logic [DATA_BITS-1:0] shifter, shift_d;
    logic [BW-1:0]        baud_cnt, baud_d;
    logic [IW-1:0]        bit_idx, bit_d;
    logic [SW-1:0]        stop_cnt, stop_d;
    logic                 ser, ser_d;
    logic                 load, baud_wrap, stop_last;

    assign tx_ready_out  = ~full;
    assign tx_serial_out = ser;
    assign tx_busy_out   = state != IDLE;
    assign tx_done_out   = (state == STOP) && stop_last;

    always_comb begin
        state_d   = state;
        full_d    = full;
        hold_d    = hold;
        shift_d   = shifter;
        bit_d     = bit_idx;
        stop_d    = stop_cnt;
        ser_d     = ser;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par;
`endif
        baud_wrap = baud_cnt == BAUD_LAST;
        stop_last = stop_cnt == STOP_LAST;
        baud_d    = baud_wrap ? '0 : baud_cnt + BW'(1);
        if (tx_valid_in && !full) begin
            full_d = 1'b1;
            hold_d = tx_data_in;
        end
        case (state)
            IDLE: load = full;
            START: if (baud_wrap) begin
                state_d = DATA;
                ser_d   = shifter[0];
                bit_d   = '0;
            end
            DATA: if (baud_wrap) begin
                if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    ser_d   = par;
`else
                    state_d = STOP;
                    ser_d   = 1'b1;
                    stop_d  = '0;
`endif
                end else begin
                    shift_d = shifter >> 1;
                    ser_d   = shifter[1];
                    bit_d   = bit_idx + IW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_wrap) begin
                state_d = STOP;
                ser_d   = 1'b1;
                stop_d  = '0;
            end
`endif
            STOP: begin
                stop_d = stop_cnt + SW'(1);
                if (stop_last) begin
                    load    = full;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading the held word starts a start bit straight away, from IDLE or
        // from the final stop cycle so back-to-back frames have no idle gap.
        if (load) begin
            state_d = START;
            ser_d   = 1'b0;
            shift_d = hold;
            full_d  = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^hold ^ (PARITY_ODD != 0);
`endif
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            full     <= 1'b0;
            hold     <= '0;
            shifter  <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            ser      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            full     <= full_d;
            hold     <= hold_d;
            shifter  <= shift_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_d;
            stop_cnt <= stop_d;
            ser      <= ser_d;
`ifdef UART_TX_PARITY_EN
            par      <= par_d;
`endif
        end
    end
endmodule
